// File: rtl/vn_accumulate_pkg.sv
// Shared definitions for the variable-node accumulate stage:
// FSM state encoding and default geometry.
package vn_accumulate_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_EMIT  = 2'd2,
      ST_POST  = 2'd3
   } vn_state_t;

   localparam int VN_WIDTH_DEF      = 8;
   localparam int VN_EXT_BITS_DEF   = 4;
   localparam int VN_MAX_DEGREE_DEF = 8;

endpackage

// File: rtl/vn_msg_buf.sv
// Per-node message store: one synchronous write port, one asynchronous read port.
// Storage is deliberately left without reset; every word is written before it is read.
module vn_msg_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vn_accumulate.sv
// Serial variable-node update: accumulate channel LLR plus incoming messages,
// then stream one extrinsic (total minus own message) per edge and the posterior.
module vn_accumulate
   import vn_accumulate_pkg::*;
#(
   parameter  int WIDTH         = VN_WIDTH_DEF,
   parameter  int EXTENDED_BITS = VN_EXT_BITS_DEF,
   parameter  int MAX_DEGREE    = VN_MAX_DEGREE_DEF,
   localparam int EW            = WIDTH + EXTENDED_BITS,
   localparam int DW            = $clog2(MAX_DEGREE + 1),
   localparam int IW            = $clog2(MAX_DEGREE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] llr_in,
   input  logic [DW-1:0]    degree_in,
   input  logic             msg_valid,
   output logic             msg_ready,
   input  logic [WIDTH-1:0] msg_in,
   output logic             ext_valid,
   input  logic             ext_ready,
   output logic [EW-1:0]    ext_out,
   output logic [IW-1:0]    ext_idx,
   output logic             ext_last,
   output logic             post_valid,
   output logic [EW-1:0]    post_out,
   output logic             busy
);

   if (MAX_DEGREE + 1 > 2 ** EXTENDED_BITS) begin : g_bad_guard_bits
      $error("vn_accumulate: EXTENDED_BITS too small for MAX_DEGREE");
   end

   function automatic logic signed [EW-1:0] sext(input logic [WIDTH-1:0] v);
      return {{EXTENDED_BITS{v[WIDTH-1]}}, v};
   endfunction

   vn_state_t               state_reg;
   logic signed [EW-1:0]    acc_reg;
   logic [DW-1:0]           deg_reg;
   logic [IW-1:0]           cnt_reg;
   logic [IW-1:0]           idx_reg;
   logic                    start_ready_reg;
   logic                    msg_ready_reg;
   logic                    ext_valid_reg;
   logic                    ext_last_reg;
   logic                    post_valid_reg;
   logic                    busy_reg;
   logic signed [EW-1:0]    ext_out_reg;
   logic signed [EW-1:0]    post_out_reg;

   logic [DW-1:0]           deg_clamped;
   logic [DW-1:0]           deg_m1;
   logic [IW-1:0]           idx_next;
   logic signed [EW-1:0]    acc_sum;
   logic                    buf_wr_en;
   logic [IW-1:0]           buf_rd_addr;
   logic [WIDTH-1:0]        buf_rd_data;

   assign deg_clamped = (degree_in > DW'(MAX_DEGREE)) ? DW'(MAX_DEGREE) : degree_in;
   assign deg_m1      = deg_reg - DW'(1);
   assign idx_next    = idx_reg + IW'(1);
   assign acc_sum     = acc_reg + sext(msg_in);
   assign buf_wr_en   = (state_reg == ST_ACCUM) && msg_valid;
   // Look one edge ahead while emitting so ext_out can be registered.
   assign buf_rd_addr = (state_reg == ST_EMIT) ? idx_next : '0;

   vn_msg_buf #(
      .WIDTH (WIDTH),
      .DEPTH (MAX_DEGREE),
      .AW    (IW)
   ) u_msg_buf (
      .clk     (clk),
      .wr_en   (buf_wr_en),
      .wr_addr (cnt_reg),
      .wr_data (msg_in),
      .rd_addr (buf_rd_addr),
      .rd_data (buf_rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         acc_reg         <= '0;
         deg_reg         <= '0;
         cnt_reg         <= '0;
         idx_reg         <= '0;
         start_ready_reg <= 1'b1;
         msg_ready_reg   <= 1'b0;
         ext_valid_reg   <= 1'b0;
         ext_last_reg    <= 1'b0;
         post_valid_reg  <= 1'b0;
         busy_reg        <= 1'b0;
         ext_out_reg     <= '0;
         post_out_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start_valid) begin
                  acc_reg         <= sext(llr_in);
                  deg_reg         <= deg_clamped;
                  cnt_reg         <= '0;
                  idx_reg         <= '0;
                  start_ready_reg <= 1'b0;
                  busy_reg        <= 1'b1;
                  if (deg_clamped != '0) begin
                     state_reg     <= ST_ACCUM;
                     msg_ready_reg <= 1'b1;
                  end else begin
                     state_reg      <= ST_POST;
                     post_valid_reg <= 1'b1;
                     post_out_reg   <= sext(llr_in);
                  end
               end
            end
            ST_ACCUM: begin
               if (msg_valid) begin
                  acc_reg <= acc_sum;
                  cnt_reg <= cnt_reg + IW'(1);
                  if (DW'(cnt_reg) == deg_m1) begin
                     state_reg     <= ST_EMIT;
                     msg_ready_reg <= 1'b0;
                     ext_valid_reg <= 1'b1;
                     idx_reg       <= '0;
                     ext_last_reg  <= (deg_reg == DW'(1));
                     // Edge 0 is still being written when the only edge arrives.
                     ext_out_reg   <= (cnt_reg == '0) ? acc_reg : acc_sum - sext(buf_rd_data);
                  end
               end
            end
            ST_EMIT: begin
               if (ext_ready) begin
                  if (ext_last_reg) begin
                     state_reg      <= ST_POST;
                     ext_valid_reg  <= 1'b0;
                     ext_last_reg   <= 1'b0;
                     post_valid_reg <= 1'b1;
                     post_out_reg   <= acc_reg;
                  end else begin
                     idx_reg      <= idx_next;
                     ext_out_reg  <= acc_reg - sext(buf_rd_data);
                     ext_last_reg <= (DW'(idx_next) == deg_m1);
                  end
               end
            end
            ST_POST: begin
               state_reg       <= ST_IDLE;
               post_valid_reg  <= 1'b0;
               start_ready_reg <= 1'b1;
               busy_reg        <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign start_ready = start_ready_reg;
   assign msg_ready   = msg_ready_reg;
   assign ext_valid   = ext_valid_reg;
   assign ext_out     = ext_out_reg;
   assign ext_idx     = idx_reg;
   assign ext_last    = ext_last_reg;
   assign post_valid  = post_valid_reg;
   assign post_out    = post_out_reg;
   assign busy        = busy_reg;

endmodule

// File: tb/tb_vn_accumulate.sv
// Directed bench for vn_accumulate: hand-computed extrinsic/posterior values,
// handshake timing, backpressure, clamping and mid-node reset.
module tb_vn_accumulate;

   localparam int WIDTH = 8;
   localparam int EW    = 12;
   localparam int DW    = 4;
   localparam int IW    = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [WIDTH-1:0] llr_in = '0;
   logic [DW-1:0]    degree_in = '0;
   logic             msg_valid = 1'b0;
   logic             msg_ready;
   logic [WIDTH-1:0] msg_in = '0;
   logic             ext_valid;
   logic             ext_ready = 1'b1;
   logic [EW-1:0]    ext_out;
   logic [IW-1:0]    ext_idx;
   logic             ext_last;
   logic             post_valid;
   logic [EW-1:0]    post_out;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;
   int msg_tab [8];
   int ext_tab [8];

   always #5 clk = ~clk;

   vn_accumulate dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .llr_in      (llr_in),
      .degree_in   (degree_in),
      .msg_valid   (msg_valid),
      .msg_ready   (msg_ready),
      .msg_in      (msg_in),
      .ext_valid   (ext_valid),
      .ext_ready   (ext_ready),
      .ext_out     (ext_out),
      .ext_idx     (ext_idx),
      .ext_last    (ext_last),
      .post_valid  (post_valid),
      .post_out    (post_out),
      .busy        (busy)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int s_ew(input logic [EW-1:0] v);
      return int'($signed(v));
   endfunction

   // One complete node; messages come from msg_tab, expected extrinsics from ext_tab.
   task automatic run_node(input string name, input int llr, input int deg_in, input int nmsg,
                           input int exp_post, input bit gap, input int stall_idx);
      int w;
      @(negedge clk);
      check({name, " start_ready"}, int'(start_ready), 1);
      start_valid = 1'b1;
      llr_in      = WIDTH'(llr);
      degree_in   = DW'(deg_in);
      @(negedge clk);
      start_valid = 1'b0;
      llr_in      = 8'h3c;
      degree_in   = '0;
      check({name, " busy"}, int'(busy), 1);
      if (nmsg == 0) begin
         check({name, " post_valid"}, int'(post_valid), 1);
         check({name, " post_out"}, s_ew(post_out), exp_post);
         check({name, " no ext"}, int'(ext_valid), 0);
      end else begin
         for (int i = 0; i < nmsg; i++) begin
            if (gap && (i % 2 == 1)) begin
               msg_valid = 1'b0;
               msg_in    = 8'h55;
               @(negedge clk);
               check({name, " ext idle in gap"}, int'(ext_valid), 0);
            end
            msg_valid = 1'b1;
            msg_in    = WIDTH'(msg_tab[i]);
            w = 0;
            while (!msg_ready && w < 20) begin
               @(negedge clk);
               w++;
            end
            check({name, " msg_ready"}, int'(msg_ready), 1);
            @(negedge clk);
         end
         msg_valid = 1'b0;
         msg_in    = 8'haa;
         check({name, " ext_valid after last msg"}, int'(ext_valid), 1);
         check({name, " msg_ready low in emit"}, int'(msg_ready), 0);
         for (int k = 0; k < nmsg; k++) begin
            w = 0;
            while (!ext_valid && w < 20) begin
               @(negedge clk);
               w++;
            end
            check({name, " ext_out"}, s_ew(ext_out), ext_tab[k]);
            check({name, " ext_idx"}, int'(ext_idx), k);
            check({name, " ext_last"}, int'(ext_last), (k == nmsg - 1) ? 1 : 0);
            if (k == stall_idx) begin
               ext_ready = 1'b0;
               repeat (3) begin
                  @(negedge clk);
                  check({name, " held valid"}, int'(ext_valid), 1);
                  check({name, " held ext_out"}, s_ew(ext_out), ext_tab[k]);
                  check({name, " held ext_idx"}, int'(ext_idx), k);
               end
               ext_ready = 1'b1;
            end
            @(negedge clk);
         end
         check({name, " post_valid"}, int'(post_valid), 1);
         check({name, " post_out"}, s_ew(post_out), exp_post);
         check({name, " ext_valid low"}, int'(ext_valid), 0);
      end
      @(negedge clk);
      check({name, " post pulse ends"}, int'(post_valid), 0);
      check({name, " start_ready back"}, int'(start_ready), 1);
      check({name, " busy low"}, int'(busy), 0);
      $display("node %s: llr %0d degree_in %0d msgs %0d post %0d", name, llr, deg_in, nmsg, exp_post);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset start_ready", int'(start_ready), 1);
      check("reset msg_ready", int'(msg_ready), 0);
      check("reset ext_valid", int'(ext_valid), 0);
      check("reset post_valid", int'(post_valid), 0);
      check("reset busy", int'(busy), 0);
      check("reset ext_out", s_ew(ext_out), 0);
      check("reset post_out", s_ew(post_out), 0);
      check("reset ext_idx", int'(ext_idx), 0);
      rst_n = 1'b1;

      // 10+5-3+7 = 19
      msg_tab[0] = 5; msg_tab[1] = -3; msg_tab[2] = 7;
      ext_tab[0] = 14; ext_tab[1] = 22; ext_tab[2] = 12;
      run_node("basic", 10, 3, 3, 19, 1'b0, -1);

      // 9 * -128 = -1152, each extrinsic -1024
      for (int i = 0; i < 8; i++) begin
         msg_tab[i] = -128;
         ext_tab[i] = -1024;
      end
      run_node("extreme", -128, 8, 8, -1152, 1'b0, -1);

      // 20+100-50+127-1 = 196
      msg_tab[0] = 100; msg_tab[1] = -50; msg_tab[2] = 127; msg_tab[3] = -1;
      ext_tab[0] = 96; ext_tab[1] = 246; ext_tab[2] = 69; ext_tab[3] = 197;
      run_node("stall", 20, 4, 4, 196, 1'b1, 1);

      run_node("deg0", -5, 0, 0, -5, 1'b0, -1);

      // 7-100 = -93, lone extrinsic is the LLR itself
      msg_tab[0] = -100;
      ext_tab[0] = 7;
      run_node("deg1", 7, 1, 1, -93, 1'b0, -1);

      // Abort a node after two of four messages.
      @(negedge clk);
      start_valid = 1'b1;
      llr_in      = 8'd50;
      degree_in   = 4'd4;
      @(negedge clk);
      start_valid = 1'b0;
      msg_valid   = 1'b1;
      msg_in      = 8'd9;
      @(negedge clk);
      msg_in      = 8'd11;
      @(negedge clk);
      msg_valid   = 1'b0;
      rst_n       = 1'b0;
      #1;
      check("abort start_ready", int'(start_ready), 1);
      check("abort msg_ready", int'(msg_ready), 0);
      check("abort busy", int'(busy), 0);
      @(negedge clk);
      check("abort ext_valid", int'(ext_valid), 0);
      check("abort post_valid", int'(post_valid), 0);
      rst_n = 1'b1;
      $display("node abort: reset after 2 of 4 msgs");

      // 1+2+3 = 6
      msg_tab[0] = 2; msg_tab[1] = 3;
      ext_tab[0] = 4; ext_tab[1] = 3;
      run_node("after_reset", 1, 2, 2, 6, 1'b0, -1);

      // degree 12 clamps to 8: 3+36 = 39, ext k = 39-(k+1)
      for (int i = 0; i < 8; i++) begin
         msg_tab[i] = i + 1;
         ext_tab[i] = 38 - i;
      end
      run_node("clamp", 3, 12, 8, 39, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
